// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: decode/writeback bus for reg_file_sb. Carries two read ports with busy flags, the writeback write port, the issue-time mark port, and the pending count and error status.
interface reg_file_sb_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0]    rd_addr1, rd_addr2, wr_addr, mark_addr;
  logic [WIDTH-1:0] rd_data1, rd_data2, wr_data;
  logic             busy1, busy2, wr_en, mark_en, err;
  logic [AW:0]      num_pending;
  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, mark_en, mark_addr,
    input  rd_data1, rd_data2, busy1, busy2, num_pending, err
  );
  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, mark_en, mark_addr,
    output rd_data1, rd_data2, busy1, busy2, num_pending, err
  );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with write-through read bypass and per-register pending scoreboard. Ports: clk, reset (async active-low), bus (slave).
module reg_file_sb #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 4,
  parameter int ZERO_REG = 0
) (
  input logic         clk,
  input logic         reset,
  reg_file_sb_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] pend, pend_nx;
  logic [AW:0]      cnt, np_q;
  logic             err_q, wr_ok, mk_ok, hit1, hit2;
  assign wr_ok = bus.wr_en && !(ZERO_REG != 0 && bus.wr_addr == '0);
  assign mk_ok = bus.mark_en && !(ZERO_REG != 0 && bus.mark_addr == '0);
  // Bypass is gated by reset so reads are 0 while reset is held low.
  assign hit1 = reset && wr_ok && bus.wr_addr == bus.rd_addr1;
  assign hit2 = reset && wr_ok && bus.wr_addr == bus.rd_addr2;
  assign bus.rd_data1 = hit1 ? bus.wr_data : mem[bus.rd_addr1];
  assign bus.rd_data2 = hit2 ? bus.wr_data : mem[bus.rd_addr2];
  assign bus.busy1 = pend[bus.rd_addr1] && !hit1;
  assign bus.busy2 = pend[bus.rd_addr2] && !hit2;
  assign bus.num_pending = np_q;
  assign bus.err = err_q;
  // Mark is applied after the write clear so a same-edge mark wins.
  always_comb begin
    pend_nx = pend;
    if (wr_ok) pend_nx[bus.wr_addr] = 1'b0;
    if (mk_ok) pend_nx[bus.mark_addr] = 1'b1;
  end
  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + {{AW{1'b0}}, pend_nx[i]};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      pend  <= '0;
      np_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (wr_ok) mem[bus.wr_addr] <= bus.wr_data;
      pend <= pend_nx;
      np_q <= cnt;
      if (mk_ok && pend[bus.mark_addr] && !(wr_ok && bus.wr_addr == bus.mark_addr)) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: randomized and directed checks of two reg_file_sb configurations against a behavioural model.
module tb_reg_file_sb;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  logic        we, me;
  logic [2:0]  wa, ma, r1, r2;
  logic [31:0] wd;
  reg_file_sb_if #(.WIDTH(16), .DEPTH(4)) ia ();
  reg_file_sb_if #(.WIDTH(32), .DEPTH(8)) ib ();
  reg_file_sb #(.WIDTH(16), .DEPTH(4), .ZERO_REG(0)) ua (.clk(clk), .reset(reset), .bus(ia.slave));
  reg_file_sb #(.WIDTH(32), .DEPTH(8), .ZERO_REG(1)) ub (.clk(clk), .reset(reset), .bus(ib.slave));
  assign ia.wr_en = we;
  assign ia.mark_en = me;
  assign ia.wr_addr = wa[1:0];
  assign ia.mark_addr = ma[1:0];
  assign ia.rd_addr1 = r1[1:0];
  assign ia.rd_addr2 = r2[1:0];
  assign ia.wr_data = wd[15:0];
  assign ib.wr_en = we;
  assign ib.mark_en = me;
  assign ib.wr_addr = wa;
  assign ib.mark_addr = ma;
  assign ib.rd_addr1 = r1;
  assign ib.rd_addr2 = r2;
  assign ib.wr_data = wd;
  logic [31:0] mm [2][8];
  bit          mp [2][8];
  bit          merr [2];
  int          vec = 0, bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  function automatic int am(int c, logic [2:0] a);
    return c == 1 ? int'(a) : int'(a) & 3;
  endfunction
  function automatic bit hit(int c, logic [2:0] ra);
    return reset && we && am(c, wa) == am(c, ra) && !(c == 1 && am(c, ra) == 0);
  endfunction
  function automatic logic [31:0] exp_rd(int c, logic [2:0] ra);
    return hit(c, ra) ? (c == 1 ? wd : wd & 32'hFFFF) : mm[c][am(c, ra)];
  endfunction
  function automatic int npend(int c);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(mp[c][i]);
    return n;
  endfunction
  task automatic clear_model();
    for (int c = 0; c < 2; c++) begin
      merr[c] = 0;
      for (int i = 0; i < 8; i++) begin mm[c][i] = '0; mp[c][i] = 0; end
    end
  endtask
  task automatic check_all();
    for (int c = 0; c < 2; c++) begin
      chk($sformatf("c%0d_rd1", c), c == 1 ? ib.rd_data1 : 32'(ia.rd_data1), exp_rd(c, r1));
      chk($sformatf("c%0d_rd2", c), c == 1 ? ib.rd_data2 : 32'(ia.rd_data2), exp_rd(c, r2));
      chk($sformatf("c%0d_busy1", c), 32'(c == 1 ? ib.busy1 : ia.busy1), 32'(reset && mp[c][am(c, r1)] && !hit(c, r1)));
      chk($sformatf("c%0d_busy2", c), 32'(c == 1 ? ib.busy2 : ia.busy2), 32'(reset && mp[c][am(c, r2)] && !hit(c, r2)));
      chk($sformatf("c%0d_npend", c), c == 1 ? 32'(ib.num_pending) : 32'(ia.num_pending), 32'(npend(c)));
      chk($sformatf("c%0d_err", c), 32'(c == 1 ? ib.err : ia.err), 32'(merr[c]));
    end
  endtask
  task automatic drive(input bit w, input logic [2:0] a, input logic [31:0] d, input bit m, input logic [2:0] k, input logic [2:0] x, input logic [2:0] y);
    @(negedge clk);
    we = w; wa = a; wd = d; me = m; ma = k; r1 = x; r2 = y;
    #1 check_all();
  endtask
  task automatic tick();
    @(posedge clk);
    if (!reset) return;
    for (int c = 0; c < 2; c++) begin
      int w = am(c, wa), k = am(c, ma);
      bit wok = we && !(c == 1 && w == 0);
      bit mok = me && !(c == 1 && k == 0);
      if (mok && mp[c][k] && !(wok && w == k)) merr[c] = 1;
      if (wok) begin mm[c][w] = c == 1 ? wd : wd & 32'hFFFF; mp[c][w] = 0; end
      if (mok) mp[c][k] = 1;
    end
  endtask
  task automatic cyc(input bit w, input logic [2:0] a, input logic [31:0] d, input bit m, input logic [2:0] k, input logic [2:0] x, input logic [2:0] y);
    drive(w, a, d, m, k, x, y);
    tick();
  endtask
  task automatic do_reset();
    @(negedge clk);
    we = 0; me = 0;
    #2 reset = 1'b0;
    #1 clear_model();
    check_all();
    chk("rst_np", 32'(ib.num_pending), 32'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask
  initial begin
    we = 0; me = 0; wa = 0; ma = 0; wd = 0; r1 = 0; r2 = 0;
    clear_model();
    #1 check_all();
    chk("rst_a_rd1", 32'(ia.rd_data1), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) cyc(1, 3'(i), $urandom, 0, 0, 3'(i), 3'(7 - i));
    drive(1, 2, 32'h0000BEEF, 0, 0, 2, 2);
    chk("beef_byp", 32'(ia.rd_data1), 32'h0000BEEF);
    tick();
    drive(0, 0, 0, 0, 0, 2, 5);
    chk("beef_store", 32'(ia.rd_data1), 32'h0000BEEF);
    tick();
    cyc(0, 0, 0, 1, 1, 1, 0);
    drive(1, 1, 32'h00000042, 0, 0, 1, 1);
    chk("sb_byp", 32'(ia.rd_data1), 32'h00000042);
    chk("sb_busy", 32'(ia.busy1), 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 3);
    chk("sb_np0", 32'(ia.num_pending), 32'd0);
    tick();
    cyc(0, 0, 0, 1, 3, 3, 3);
    cyc(1, 3, 32'h1234ABCD, 1, 3, 3, 0);
    drive(0, 0, 0, 0, 0, 3, 3);
    chk("col_busy", 32'(ia.busy1), 32'd1);
    chk("col_data", 32'(ia.rd_data1), 32'h0000ABCD);
    chk("col_err", 32'(ia.err), 32'd0);
    tick();
    cyc(1, 3, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 1, 1, 0);
    cyc(0, 0, 0, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) cyc(1, 3'(i), $urandom, 0, 0, 1, 2);
    drive(0, 0, 0, 0, 0, 1, 0);
    chk("err_sticky", 32'(ia.err), 32'd1);
    tick();
    do_reset();
    drive(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0);
    chk("z_rd", ib.rd_data1, 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("z_np", 32'(ib.num_pending), 32'd0);
    chk("z_busy", 32'(ib.busy1), 32'd0);
    tick();
    for (int i = 1; i < 8; i++) cyc(0, 0, 0, 1, 3'(i), 3'(i), 0);
    drive(0, 0, 0, 0, 0, 7, 0);
    chk("z_np7", 32'(ib.num_pending), 32'd7);
    chk("z_err", 32'(ib.err), 32'd0);
    tick();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(59) == 0) do_reset();
      else cyc(1'($urandom_range(1)), 3'($urandom), $urandom, $urandom_range(3) == 0, 3'($urandom), 3'($urandom), 3'($urandom));
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with write-through read bypass and a per-register pending scoreboard for the pipelined CPU. Sits between decode (read ports, issue-time destination marking) and writeback (write port). Replaces the fixed 4 x 16-bit, level-triggered register array with a clocked, reset-safe store that also reports read-after-write hazards to the stall logic.

## Interface
- WIDTH, 16, data word width in bits (>= 1)
- DEPTH, 4, number of registers; power of two, >= 2
- ZERO_REG, 0, when 1 register 0 reads as 0 and ignores writes and marks
- AW (localparam), $clog2(DEPTH), address width

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- rd_addr1  in  AW  read port 1 address
- rd_data1  out  WIDTH  read port 1 data (combinational)
- busy1  out  1  register at rd_addr1 has an outstanding producer
- rd_addr2  in  AW  read port 2 address
- rd_data2  out  WIDTH  read port 2 data (combinational)
- busy2  out  1  register at rd_addr2 has an outstanding producer
- wr_en  in  1  writeback write strobe
- wr_addr  in  AW  writeback destination
- wr_data  in  WIDTH  writeback data
- mark_en  in  1  issue marks mark_addr as pending
- mark_addr  in  AW  issued instruction's destination
- num_pending  out  AW+1  registered count of pending bits
- err  out  1  sticky: mark issued to already-pending register

## Operation
- Storage: DEPTH x WIDTH registers plus DEPTH pending bits.
- Write: on rising clk with wr_en=1, reg[wr_addr] <= wr_data and pending[wr_addr] <= 0.
- Mark: on rising clk with mark_en=1, pending[mark_addr] <= 1.
- Same-edge mark and write to the same address: data written, pending ends 1 (mark wins; new producer outstanding).
- Read: rd_dataN = wr_data when wr_en=1 and wr_addr==rd_addrN (bypass), else reg[rd_addrN]. Both ports may hit the same address.
- busyN = pending[rd_addrN] AND NOT (wr_en AND wr_addr==rd_addrN). A same-cycle mark does not raise busy until the next cycle.
- ZERO_REG=1: address 0 writes and marks ignored, rd_data=0 and busy=0 for address 0, no bypass at address 0, never counted.
- err: set on rising clk when mark_en=1, pending[mark_addr]=1 and not cleared by a same-edge write to that address (ignored address 0 excluded). Cleared only by reset.
- num_pending: registered population count of the next-state pending vector; range 0..DEPTH.

## Timing
- Read latency 0 (combinational from address and write port); write and mark take effect at the edge, visible from storage the following cycle.
- Reset low (any time, asynchronous): all registers 0, pending 0, num_pending 0, err 0. Hence rd_data1/2 = 0 and busy1/2 = 0 while reset is low. Bypass is disabled while reset is low.
- Reset released: first edge with reset=1 performs normal updates. A write or mark coinciding with reset assertion is lost.
- No X propagation: all state defined after reset. No initial blocks relied on for function.

## Test plan
- Reset: after writes to all registers, drive reset=0 mid-cycle -> rd_data1/2=0, busy=0, num_pending=0, err=0 immediately, before next edge.
- Write/bypass: wr_en=1, wr_addr=2, wr_data=16'hBEEF, rd_addr1=2 same cycle -> rd_data1=16'hBEEF combinationally; next cycle wr_en=0 -> still 16'hBEEF from storage.
- Scoreboard: mark r1 -> next cycle busy1=1 (rd_addr1=1), num_pending=1; write r1 with 16'h0042 -> busy1=0 in that cycle with rd_data1=16'h0042; next cycle num_pending=0.
- Collision: same edge mark_addr=3 and wr_addr=3 with r3 pending -> r3 data updated, pending stays 1, num_pending unchanged, err=0.
- Error: mark r1 twice on consecutive edges with no write -> err=1 after second edge, remains 1 until reset.
- ZERO_REG=1, DEPTH=8, WIDTH=32: write 32'hFFFFFFFF to r0 and mark r0 -> rd_data=0, busy=0, num_pending=0, err=0; mark all r1..r7 -> num_pending=7.
